ntt_sequencer: RTL
==================

Name: ntt_sequencer

Overview:
Parametrised control sequencer for the multi-core NTT datapath. Generates per-cycle read addresses, stage indices (log_m, log_t, group), buffer select, write-back enables and router-aligned delayed copies for an array of 2^LOG_CORE_COUNT butterfly cores. It generalises the fixed N=4096 controller to any transform size and core count. It adds inverse (Gentleman-Sande, reversed stage order) mode and a start/busy/done handshake.

Parameters:
LOG_N, 12, log2 of transform length N (>= LOG_CORE_COUNT+3)
LOG_CORE_COUNT, 4, log2 of core count C
PIPE_STAGES, 11, read-to-writeback latency of core+router loop (>= 5)
Derived: AW = LOG_N-1-LOG_CORE_COUNT, D = 2^AW, LW = $clog2(LOG_N)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start request, sampled in IDLE only
inverse  in  1  0 = forward NTT, 1 = inverse; captured with start
busy  out  1  high while state != IDLE
done  out  1  one-cycle completion pulse
log_m  out  LW  current stage log_m
log_t  out  LW  current stage log_t (= LOG_N-1-log_m)
group  out  AW  current group index in staggered stages
even_addr  out  AW  read address for even-indexed cores
odd_addr  out  AW  read address for odd-indexed cores
read_select  out  1  ping-pong bank being read
wr_en  out  1  write-back enable for all cores
write_select  out  1  read_select delayed PIPE_STAGES cycles
rt_log_m  out  LW  log_m delayed PIPE_STAGES-4
rt_log_t  out  LW  log_t delayed PIPE_STAGES-4
rt_even_addr  out  AW  even_addr delayed PIPE_STAGES-4
rt_odd_addr  out  AW  odd_addr delayed PIPE_STAGES-4
out_valid  out  1  router output valid (drain reads delayed PIPE_STAGES-2)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs and all delay-line stages 0.
- States: IDLE, COMPUTE, DRAIN, FLUSH.
- IDLE: start=1 at edge -> COMPUTE; capture inverse; read_select=0; first stage driven the next cycle. Forward: log_t=LOG_N-1. Inverse: log_t=0.
- Stage order: forward log_t descends LOG_N-1..0; inverse ascends 0..LOG_N-1. log_m = LOG_N-1-log_t always.
- Each stage lasts exactly D cycles.
- Linear stage (log_t >= AW or log_t == 0): even_addr = odd_addr = 0..D-1; group=0.
- Staggered stage (1 <= log_t < AW): B = 2^log_t; groups g = 0..D/B-1.
  - Per group, even_addr = g*B .. g*B+B-1.
  - odd_addr starts at g*B+B/2, increments, and wraps to g*B after g*B+B-1.
  - group = g.
- Stage boundary: read_select toggles; log_t steps; addresses restart at 0 (odd per rule above).
- After the last compute cycle -> DRAIN: D cycles, linear addresses, read_select toggled once more, log_m/log_t hold last stage values.
- After the last drain cycle -> FLUSH for PIPE_STAGES-2 cycles -> IDLE. done=1 on the first IDLE cycle only.
- busy=1 exactly in COMPUTE, DRAIN and FLUSH.
- wr_en = compute-cycle flag delayed PIPE_STAGES. It is 0 for drain reads.
- out_valid = drain-cycle flag delayed PIPE_STAGES-2.
- Delay lines are free-running shift registers. They are cleared only by reset.
- start while busy: ignored, no effect on sequence.
- start coincident with done: accepted, a new run begins.
- inverse changing mid-run: ignored.
- rst_n low mid-run: immediate IDLE and all outputs 0. No done pulse.
- Total run, start edge to done: LOG_N*D + D + PIPE_STAGES-2 + 1 cycles.

Test Plan:
- LOG_N=6, LOG_CORE_COUNT=1, PIPE_STAGES=11, forward, start at cycle 0 ->
  - compute cycles 1..96; log_t 5,4,3,2,1,0; stages at log_t 5,4,0 linear 0..15.
  - DRAIN cycles 97..112; wr_en high cycles 12..107; out_valid high 106..121.
  - done at 122 only; busy high 1..121.
- Same config, stage log_t=2 (cycles 49..64) ->
  - even 0..15 linear; group 0,0,0,0,1,...,3.
  - odd 2,3,0,1, 6,7,4,5, 10,11,8,9, 14,15,12,13.
- inverse=1 -> log_t sequence 0,1,2,3,4,5; log_m 5..0; same per-stage address rules; done at cycle 122.
- read_select toggles at cycles 17,33,49,65,81,97. write_select equals read_select 11 cycles later. rt_* equal the source signals 7 cycles later.
- start pulsed at cycles 40 and 122 (coincident with done) -> first pulse ignored; second run begins, compute cycle 123 with even_addr=0.
- rst_n low at cycle 60 for 1 cycle -> all outputs 0 immediately; no done; a later start yields a clean full 122-cycle run.

Source files
------------

// File: rtl/ntt_sequencer_if.sv
// ntt_sequencer_if: handshake and control bus between the NTT sequencer and the core array.
// Ports (master = sequencer view):
//   in : start, inverse
//   out: busy, done, log_m, log_t, group, even_addr, odd_addr, read_select,
//        wr_en, write_select, rt_log_m, rt_log_t, rt_even_addr, rt_odd_addr, out_valid
interface ntt_sequencer_if #(
  parameter int LOG_N = 12,
  parameter int LOG_CORE_COUNT = 4
);
  localparam int AW = LOG_N-1-LOG_CORE_COUNT;
  localparam int LW = $clog2(LOG_N);
  logic start, inverse, busy, done, read_select, wr_en, write_select, out_valid;
  logic [LW-1:0] log_m, log_t, rt_log_m, rt_log_t;
  logic [AW-1:0] group, even_addr, odd_addr, rt_even_addr, rt_odd_addr;
  modport master (
    input start, inverse,
    output busy, done, log_m, log_t, group, even_addr, odd_addr, read_select,
    wr_en, write_select, rt_log_m, rt_log_t, rt_even_addr, rt_odd_addr, out_valid
  );
  modport slave (
    output start, inverse,
    input busy, done, log_m, log_t, group, even_addr, odd_addr, read_select,
    wr_en, write_select, rt_log_m, rt_log_t, rt_even_addr, rt_odd_addr, out_valid
  );
endinterface

// File: rtl/ntt_sequencer.sv
// ntt_sequencer: stage/address/bank sequencer for a 2^LOG_CORE_COUNT-core NTT datapath.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : ntt_sequencer_if master (start/inverse in; stage indices, addresses,
//           bank selects, write-back enable and router-aligned delayed copies out)
module ntt_sequencer #(
  parameter int LOG_N = 12,
  parameter int LOG_CORE_COUNT = 4,
  parameter int PIPE_STAGES = 11
) (
  input logic clk,
  input logic rst_n,
  ntt_sequencer_if.master bus
);
  localparam int AW = LOG_N-1-LOG_CORE_COUNT;
  localparam int LW = $clog2(LOG_N);
  localparam int FW = $clog2(PIPE_STAGES);
  localparam int RW = 2*LW+2*AW;
  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, FLUSH} state_t;
  state_t state, state_n;
  logic [AW-1:0] cnt, cnt_n, msk, half, odd, grp;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [LW-1:0] lt, lt_n, lm, lm_n;
  logic inv, inv_n, rsel, rsel_n, done_q, done_n, comp, drn, stag, last_stage;
  logic [PIPE_STAGES-1:0] wr_d, ws_d;
  logic [PIPE_STAGES-3:0] ov_d;
  logic [RW-1:0] rt_d [PIPE_STAGES-4];
  assign comp = state == COMPUTE;
  assign drn = state == DRAIN;
  // Staggered stages rotate the odd address by half a group; msk selects the
  // in-group bits and half is its top bit (B/2). Outside them msk=0, so odd=cnt.
  assign stag = comp && lt != '0 && lt < LW'(AW);
  assign msk = stag ? (AW'(1) << lt) - AW'(1) : '0;
  assign half = msk ^ (msk >> 1);
  assign odd = (cnt & ~msk) | ((cnt + half) & msk);
  assign grp = stag ? cnt >> lt : '0;
  assign last_stage = inv ? lt == LW'(LOG_N-1) : lt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      fcnt <= '0;
      lt <= '0;
      lm <= '0;
      inv <= 1'b0;
      rsel <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      fcnt <= fcnt_n;
      lt <= lt_n;
      lm <= lm_n;
      inv <= inv_n;
      rsel <= rsel_n;
      done_q <= done_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    fcnt_n = fcnt;
    lt_n = lt;
    lm_n = lm;
    inv_n = inv;
    rsel_n = rsel;
    done_n = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        state_n = COMPUTE;
        inv_n = bus.inverse;
        lt_n = bus.inverse ? '0 : LW'(LOG_N-1);
        lm_n = bus.inverse ? LW'(LOG_N-1) : '0;
        cnt_n = '0;
        rsel_n = 1'b0;
      end
      COMPUTE: begin
        cnt_n = cnt + AW'(1);
        if (&cnt) begin
          rsel_n = ~rsel;
          state_n = last_stage ? DRAIN : COMPUTE;
          lt_n = last_stage ? lt : inv ? lt + LW'(1) : lt - LW'(1);
          lm_n = last_stage ? lm : inv ? lm - LW'(1) : lm + LW'(1);
        end
      end
      DRAIN: begin
        cnt_n = cnt + AW'(1);
        state_n = &cnt ? FLUSH : DRAIN;
        fcnt_n = '0;
      end
      FLUSH: begin
        fcnt_n = fcnt + FW'(1);
        done_n = fcnt == FW'(PIPE_STAGES-3);
        state_n = done_n ? IDLE : FLUSH;
      end
    endcase
  end
  // Free-running delay lines aligning control with the core/router pipeline.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_d <= '0;
      ws_d <= '0;
      ov_d <= '0;
      for (int i = 0; i < PIPE_STAGES-4; i++) rt_d[i] <= '0;
    end else begin
      wr_d <= {wr_d[PIPE_STAGES-2:0], comp};
      ws_d <= {ws_d[PIPE_STAGES-2:0], rsel};
      ov_d <= {ov_d[PIPE_STAGES-4:0], drn};
      rt_d[0] <= {lm, lt, cnt, odd};
      for (int i = 1; i < PIPE_STAGES-4; i++) rt_d[i] <= rt_d[i-1];
    end
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  assign bus.log_m = lm;
  assign bus.log_t = lt;
  assign bus.group = grp;
  assign bus.even_addr = cnt;
  assign bus.odd_addr = odd;
  assign bus.read_select = rsel;
  assign bus.wr_en = wr_d[PIPE_STAGES-1];
  assign bus.write_select = ws_d[PIPE_STAGES-1];
  assign bus.out_valid = ov_d[PIPE_STAGES-3];
  assign {bus.rt_log_m, bus.rt_log_t, bus.rt_even_addr, bus.rt_odd_addr} = rt_d[PIPE_STAGES-5];
endmodule
